// File: rtl/bank_sched_pkg.sv
// Shared types and constants for the bank scheduler front end.
package bank_sched_pkg;

  localparam int ADDR_W   = 32;
  localparam int REQ_ID_W = 32;
  localparam int CYCLE_W  = 64;

  typedef struct packed {
    logic                rd_en;
    logic                wr_en;
    logic [ADDR_W-1:0]   addr;
    logic [31:0]         id;
    logic [63:0]         enq_cycle;
  } bank_req_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with show-ahead read data taken from registered storage.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  T                         wr_data_i,
  input  logic                     rd_en_i,
  output T                         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  T                   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Next entry count from the push/pop pair.
  always_comb begin
    count_d = count_q;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointers and count; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bank_request_queue.sv
// Per-bank request queue: ID/cycle stamping, malformed filtering, occupancy stats.
module bank_request_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_rd_en,
  input  logic                    in_wr_en,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [63:0]             globalCycle,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_rd_en,
  output logic                    out_wr_en,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [31:0]             out_request_id,
  output logic [63:0]             out_enq_cycle,
  output logic                    req_fire,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [$clog2(DEPTH):0]  max_occupancy,
  output logic [31:0]             malformed_count
);

  import bank_sched_pkg::*;

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PKG_AW = bank_sched_pkg::ADDR_W;

  logic             accept, well_formed, push, pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] count, occ_next;
  logic [CNT_W-1:0] max_occ_q, max_occ_d;
  logic [31:0]      next_id_q, next_id_d;
  logic [31:0]      malformed_q, malformed_d;
  bank_req_t        wr_entry, head;

  assign in_ready    = !fifo_full;
  assign accept      = in_valid && in_ready;
  assign well_formed = in_rd_en ^ in_wr_en;
  assign push        = accept && well_formed;
  // Reset cycle must never look like a dequeue, even with old entries still stored.
  assign out_valid   = !fifo_empty && !reset;
  assign req_fire    = out_valid && out_ready;
  assign pop         = req_fire;

  assign wr_entry = '{rd_en:     in_rd_en,
                      wr_en:     in_wr_en,
                      addr:      PKG_AW'(in_addr),
                      id:        next_id_q,
                      enq_cycle: globalCycle};

  sync_fifo #(.T(bank_req_t), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_data_i (wr_entry),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (count)
  );

  // Head fields are forced to zero whenever nothing valid is presented.
  assign out_rd_en      = out_valid ? head.rd_en : 1'b0;
  assign out_wr_en      = out_valid ? head.wr_en : 1'b0;
  assign out_addr       = out_valid ? ADDR_W'(head.addr) : '0;
  assign out_request_id = out_valid ? head.id : '0;
  assign out_enq_cycle  = out_valid ? head.enq_cycle : '0;
  assign occupancy      = count;
  assign max_occupancy  = max_occ_q;
  assign malformed_count = malformed_q;

  // Next-cycle occupancy and statistics updates.
  always_comb begin
    occ_next = count;
    if (push && !pop)      occ_next = count + 1'b1;
    else if (pop && !push) occ_next = count - 1'b1;
    max_occ_d   = (occ_next > max_occ_q) ? occ_next : max_occ_q;
    next_id_d   = push ? next_id_q + 32'd1 : next_id_q;
    malformed_d = (accept && !well_formed) ? sat_inc32(malformed_q) : malformed_q;
  end

  // ID allocator and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      next_id_q   <= '0;
      malformed_q <= '0;
      max_occ_q   <= '0;
    end else begin
      next_id_q   <= next_id_d;
      malformed_q <= malformed_d;
      max_occ_q   <= max_occ_d;
    end
  end

endmodule

// File: tb/tb_bank_request_queue.sv
// Directed bench for bank_request_queue.
module tb_bank_request_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_rd_en, in_wr_en;
  logic [31:0] in_addr;
  logic [63:0] globalCycle;
  logic        out_valid, out_ready, out_rd_en, out_wr_en;
  logic [31:0] out_addr, out_request_id;
  logic [63:0] out_enq_cycle;
  logic        req_fire;
  logic [3:0]  occupancy, max_occupancy;
  logic [31:0] malformed_count;

  int passed = 0;
  int total  = 0;

  bank_request_queue #(.DEPTH(8), .ADDR_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_rd_en        (in_rd_en),
    .in_wr_en        (in_wr_en),
    .in_addr         (in_addr),
    .globalCycle     (globalCycle),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_rd_en       (out_rd_en),
    .out_wr_en       (out_wr_en),
    .out_addr        (out_addr),
    .out_request_id  (out_request_id),
    .out_enq_cycle   (out_enq_cycle),
    .req_fire        (req_fire),
    .occupancy       (occupancy),
    .max_occupancy   (max_occupancy),
    .malformed_count (malformed_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [63:0] gc);
    in_valid    = v;
    in_rd_en    = rd;
    in_wr_en    = wr;
    in_addr     = a;
    globalCycle = gc;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_max_occ", max_occupancy, 0);
    chk("rst_malformed", malformed_count, 0);
    chk("rst_out_id_zero", out_request_id, 0);

    // Three reads streamed with out_ready high
    drive(1'b1, 1'b1, 1'b0, 32'h100, 64'd10);
    tick();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h104, 64'd11);
    settle();
    chk("s1_fire0", req_fire, 1);
    chk("s1_id0", out_request_id, 0);
    chk("s1_cyc0", out_enq_cycle, 10);
    chk("s1_addr0", out_addr, 32'h100);
    chk("s1_rd0", out_rd_en, 1);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h108, 64'd12);
    settle();
    chk("s1_id1", out_request_id, 1);
    chk("s1_cyc1", out_enq_cycle, 11);
    chk("s1_addr1", out_addr, 32'h104);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd13);
    settle();
    chk("s1_fire2", req_fire, 1);
    chk("s1_id2", out_request_id, 2);
    chk("s1_cyc2", out_enq_cycle, 12);
    tick();
    chk("s1_drained", out_valid, 0);
    chk("s1_id_zeroed", out_request_id, 0);
    chk("s1_max_occ", max_occupancy, 1);

    // Fill to DEPTH with out_ready low
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h200 + 32'(i * 4), 64'd20 + 64'(i));
      tick();
    end
    chk("fill_in_ready", in_ready, 0);
    chk("fill_occ", occupancy, 8);
    drive(1'b1, 1'b0, 1'b1, 32'h999, 64'd40);
    tick();
    chk("fill_held_occ", occupancy, 8);
    chk("fill_head_stable", out_request_id, 0);
    chk("fill_head_addr", out_addr, 32'h200);
    out_ready = 1'b1;
    settle();
    chk("fill_pop_fire", req_fire, 1);
    tick();
    out_ready = 1'b0;
    settle();
    chk("fill_occ_after_pop", occupancy, 7);
    chk("fill_in_ready_back", in_ready, 1);
    chk("fill_head_next", out_request_id, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    settle();
    chk("fill_refill_occ", occupancy, 8);
    chk("fill_max_occ", max_occupancy, 8);

    // Malformed requests are swallowed
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'h300, 64'd50);
    tick();
    chk("mal_count1", malformed_count, 1);
    chk("mal_no_valid", out_valid, 0);
    chk("mal_occ", occupancy, 0);
    drive(1'b1, 1'b0, 1'b1, 32'h304, 64'd51);
    tick();
    chk("mal_wr_valid", out_valid, 1);
    chk("mal_wr_id", out_request_id, 0);
    chk("mal_wr_flag", out_wr_en, 1);
    chk("mal_rd_flag", out_rd_en, 0);
    drive(1'b1, 1'b0, 1'b0, 32'h308, 64'd52);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    settle();
    chk("mal_count2", malformed_count, 2);
    chk("mal_occ_after", occupancy, 1);

    // Simultaneous enqueue/dequeue at occupancy 4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h400 + 32'(i), 64'd60 + 64'(i));
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h404, 64'd64);
    tick();
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    settle();
    chk("sim_occ", occupancy, 4);
    chk("sim_head", out_request_id, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("sim_order", out_request_id, 64'(k));
      tick();
    end
    chk("sim_empty", occupancy, 0);
    out_ready = 1'b0;

    // ID wrap
    do_reset();
    force dut.next_id_q = 32'hFFFF_FFFE;
    #1;
    release dut.next_id_q;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 32'h500 + 32'(i), 64'd70 + 64'(i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    out_ready = 1'b1;
    settle();
    chk("wrap_id0", out_request_id, 32'hFFFF_FFFE);
    tick();
    chk("wrap_id1", out_request_id, 32'hFFFF_FFFF);
    tick();
    chk("wrap_id2", out_request_id, 0);
    tick();
    out_ready = 1'b0;

    // Reset with entries queued
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h600 + 32'(i), 64'd80 + 64'(i));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    settle();
    chk("rq_occ5", occupancy, 5);
    reset     = 1'b1;
    out_ready = 1'b1;
    settle();
    chk("rq_no_fire_in_reset", req_fire, 0);
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    settle();
    chk("rq_out_valid", out_valid, 0);
    chk("rq_occ", occupancy, 0);
    chk("rq_max_occ", max_occupancy, 0);
    drive(1'b1, 1'b0, 1'b1, 32'h700, 64'd90);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 64'd0);
    settle();
    chk("rq_first_id", out_request_id, 0);
    chk("rq_first_cycle", out_enq_cycle, 90);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
